// File: rtl/i2c_master_tx_if.sv
// Control and bus bundle for the write-only I2C master.
// master: start/tx_data/sda_in in; scl_out/sda_out/busy/done/ack_err out.
interface i2c_master_tx_if #(
  parameter int DATA_W = 12
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              scl_out;
  logic              sda_out;
  logic              sda_in;
  logic              busy;
  logic              done;
  logic              ack_err;

  modport master (
    input  start, tx_data, sda_in,
    output scl_out, sda_out, busy, done, ack_err
  );

  modport slave (
    output start, tx_data, sda_in,
    input  scl_out, sda_out, busy, done, ack_err
  );
endinterface

// File: rtl/i2c_master_tx.sv
// Write-only I2C master: START, {addr,W}, two data bytes, STOP.
// Ports: clk, rst (sync high), bus (start/tx_data/sda_in -> scl/sda/busy/done/ack_err).
module i2c_master_tx #(
  parameter int         CLK_DIV    = 10,
  parameter logic [6:0] SLAVE_ADDR = 7'd52
) (
  input logic           clk,
  input logic           rst,
  i2c_master_tx_if.master bus
);

  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BYTE, S_ACK, S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [1:0]      phase_q, phase_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic [7:0]      shift_q, shift_d;
  logic [11:0]     data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ack_err_q, ack_err_d;
  logic            scl_q, scl_d;
  logic            sda_q, sda_d;
  logic            wrap;

  assign wrap = (qcnt_q == QMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      phase_q   <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    scl_d     = 1'b1;
    sda_d     = 1'b1;

    if (state_q != S_IDLE) begin
      qcnt_d = wrap ? '0 : qcnt_q + 1'b1;
      if (wrap) phase_d = phase_q + 2'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        qcnt_d  = '0;
        phase_d = '0;
        if (bus.start) begin
          state_d   = S_START;
          shift_d   = {SLAVE_ADDR, 1'b0};
          data_d    = bus.tx_data;
          ack_err_d = 1'b0;
          byte_d    = '0;
          bit_d     = 3'd7;
          busy_d    = 1'b1;
        end
      end
      S_START: begin
        if (wrap && phase_q == 2'd2) begin
          state_d = S_BYTE;
          phase_d = '0;
        end
      end
      S_BYTE: begin
        if (wrap && phase_q == 2'd3) begin
          if (bit_q == 3'd0) begin
            state_d = S_ACK;
          end else begin
            bit_d   = bit_q - 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
      end
      S_ACK: begin
        if (wrap && phase_q == 2'd2 && bus.sda_in)
          ack_err_d = 1'b1;
        // ack_err_q only rises inside this frame, so it marks a NACK here
        if (wrap && phase_q == 2'd3) begin
          if (ack_err_q || byte_q == 2'd2) begin
            state_d = S_STOP;
          end else begin
            state_d = S_BYTE;
            byte_d  = byte_q + 2'd1;
            bit_d   = 3'd7;
            shift_d = (byte_q == 2'd0) ? data_q[11:4]
                                       : {data_q[3:0], 4'h0};
          end
        end
      end
      S_STOP: begin
        if (wrap && phase_q == 2'd2) begin
          state_d = S_IDLE;
          phase_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line levels come from the next state so the registered
    // outputs line up with the state they belong to.
    unique case (state_d)
      S_START: begin
        scl_d = (phase_d != 2'd2);
        sda_d = (phase_d == 2'd0);
      end
      S_BYTE: begin
        scl_d = phase_d[0] ^ phase_d[1];
        sda_d = shift_d[7];
      end
      S_ACK: begin
        scl_d = phase_d[0] ^ phase_d[1];
      end
      S_STOP: begin
        scl_d = (phase_d != 2'd0);
        sda_d = (phase_d == 2'd2);
      end
      default: ;
    endcase
  end

  assign bus.scl_out = scl_q;
  assign bus.sda_out = sda_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ack_err = ack_err_q;

endmodule

// File: doc/i2c_master_tx.md
Name: i2c_master_tx

Overview:
Write-only I2C master that produces the bus traffic consumed by i2c_slave, which sits directly downstream of it.
- On a start request it sends one fixed frame: START, address byte {SLAVE_ADDR, W=0}, data byte {tx_data[11:4]}, data byte {tx_data[3:0], 4'b0000}, STOP.
- Drives SCL/SDA as open-drain enables and samples SDA for the slave ACKs.
- Reports completion and NACK to the local controller.

Parameters:
CLK_DIV, 10, clk cycles per quarter-bit phase (50 MHz clk -> 200 ns phase); must be >= 2
SLAVE_ADDR, 7'd52, 7-bit target address, sent MSB first
DATA_W, 12, payload width; fixed at 12 (two-byte frame, lower 4 bits padded)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request; accepted only while busy=0
tx_data  in  12  payload; sampled on the accepting edge
scl_out  out  1  1 = release SCL (pulled high), 0 = drive SCL low
sda_out  out  1  1 = release SDA, 0 = drive SDA low
sda_in  in  1  resolved SDA line level, sampled for ACK
busy  out  1  high from the cycle after acceptance until the frame ends
done  out  1  one-cycle pulse at frame end (success or NACK)
ack_err  out  1  set when any ACK slot read 1; held until the next accepted start

Behaviour:
- Reset (rst=1 at an edge): scl_out=1, sda_out=1, busy=0, done=0, ack_err=0, state=IDLE, all counters zeroed. A mid-frame reset releases both lines on the next edge; no STOP is generated.
- Timebase: a quarter counter runs 0..CLK_DIV-1 and advances the phase on wrap. It runs only while busy.
- States: IDLE -> START -> BYTE -> ACK -> (BYTE | STOP) -> IDLE.
- IDLE: both lines released. If start=1 and busy=0, latch the shift byte {SLAVE_ADDR,0}, latch tx_data, clear ack_err, go to START. start while busy is ignored.
- START: 3 quarters.
  - Q0: SCL=1, SDA=1.
  - Q1: SCL=1, SDA=0 (the falling SDA with SCL high is the START condition).
  - Q2: SCL=0, SDA=0.
- BYTE: 8 bits, MSB first, 4 quarters per bit.
  - Q0: SCL=0, SDA=bit.
  - Q1, Q2: SCL=1, SDA held.
  - Q3: SCL=0.
  - SDA changes only in Q0, so it never toggles while SCL is high.
- ACK: one 4-quarter bit with SDA released (sda_out=1).
  - Sample sda_in on the last clk of Q2.
  - If the sample is 1: set ack_err and go to STOP, skipping the remaining bytes.
  - Otherwise load the next byte: byte index 0 -> tx_data[11:4]; 1 -> {tx_data[3:0],4'h0}; after byte 2 go to STOP.
- STOP: 3 quarters.
  - Q0: SCL=0, SDA=0.
  - Q1: SCL=1, SDA=0.
  - Q2: SCL=1, SDA=1 (the rising SDA with SCL high is the STOP condition).
- Frame end: the cycle after STOP Q2 completes, busy=0 and done=1 for exactly one cycle, state=IDLE. A start arriving in that same cycle is accepted.
- Timing: a full successful frame is 3 + 3*9*4 + 3 = 114 quarters. busy is high for exactly 114*CLK_DIV cycles.
- NACK on byte k (k=0..2) shortens the frame to 3 + (k+1)*36 + 3 quarters.
- No clock stretching (SCL is not read back), no repeated start, no read transfers.
- All outputs are registered, so there is no combinational path from sda_in or start to the outputs.

Test Plan:
1. Reset, then start with tx_data=12'hABC against i2c_slave (tri1 pull-ups) -> three ACKs, ack_err=0, done pulse after 1140 clks, slave rx_data=12'hABC, slave done asserted.
2. Monitor on the bus during scenario 1 -> decoded bytes 0x68, 0xAB, 0xC0; exactly one START and one STOP; no SDA edge while SCL=1 except at START/STOP.
3. SLAVE_ADDR=7'd53 with a slave at 52 -> address ACK slot reads 1, ack_err=1, STOP issued; busy high for (3+36+3)*10=420 clks; slave rx_data unchanged.
4. start pulsed again mid-frame with tx_data=12'h123 -> ignored; frame completes carrying 12'hABC; then back-to-back start with 12'h123 in the done cycle -> second frame delivers 12'h123.
5. rst asserted during data byte 1 -> next edge: scl_out=sda_out=1, busy=0, done=0, ack_err=0; a subsequent start with 12'h5A5 completes with rx_data=12'h5A5.
6. tx_data=12'h000 and 12'hFFF -> bytes 0x00,0x00 and 0xFF,0xF0 on the bus; both frames ACKed.
